vga_pattern_gen: RTL

- Parametrised successor to the fixed 640x480 test-pattern top: integrated timing generator plus multi-mode pattern source, with registered RGB/sync outputs aligned to each other.
- Timing, colour depth, downscale factor and pattern set are generic.
- Adds runtime mode select, a frame-boundary mode latch, a per-frame animated bouncing box, a pixel-enable and a frame counter.
- Sits between the pixel clock domain and the board VGA pins. Used for bring-up and for monitor/cable checks.

---
 rtl/vga_pattern_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// vga_pattern_gen: VGA timing generator + selectable test patterns  (rev 1.0)
// ============================================================================
module vga_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int COLOR_BITS  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int CHECK_LOG2  = 6,
  parameter int BOX_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [2:0]              mode_i,
  input  logic [3*COLOR_BITS-1:0] solid_rgb_i,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame_start,
  output logic [15:0]             frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int CW      = (H_W > V_W) ? H_W : V_W;
  localparam int W       = H_ACTIVE >> SCALE_SHIFT;
  localparam int HS      = V_ACTIVE >> SCALE_SHIFT;

  localparam logic           SYNC_ACT   = (SYNC_POL != 0);
  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0]  BX_MAX     = CW'(W - BOX_SIZE);
  localparam logic [CW-1:0]  BY_MAX     = CW'(HS - BOX_SIZE);
  localparam logic [CW:0]    BOX_V      = (CW+1)'(BOX_SIZE);

  if (BOX_SIZE >= W || BOX_SIZE >= HS) begin : g_bad_box
    $error("BOX_SIZE must be smaller than the scaled active width and height");
  end
  if (4 + COLOR_BITS >= CW) begin : g_bad_color
    $error("COLOR_BITS too wide for the gradient slice of the scaled coordinate");
  end
  if (CHECK_LOG2 >= CW) begin : g_bad_check
    $error("CHECK_LOG2 exceeds the scaled coordinate width");
  end

  logic [H_W-1:0]        h_cnt;
  logic [V_W-1:0]        v_cnt;
  logic [2:0]            mode_q;
  logic [CW-1:0]         bx, by;
  logic                  dx, dy;
  logic                  tick, vis, hs_act, vs_act, chk, in_box;
  logic [CW-1:0]         x, y, bx_eff, by_eff;
  logic [CW:0]           bx_step, by_step;
  logic [2:0]            mode_eff, bar;
  logic [COLOR_BITS-1:0] grad_r, grad_g, pix_r, pix_g, pix_b;

  // Returns {new direction, new position}; the reversal and its step share one tick.
  function automatic logic [CW:0] box_step(input logic [CW-1:0] pos, input logic fwd,
                                           input logic [CW-1:0] pmax);
    if (fwd) box_step = (pos == pmax) ? {1'b0, pos - CW'(1)} : {1'b1, pos + CW'(1)};
    else     box_step = (pos == '0)   ? {1'b1, pos + CW'(1)} : {1'b0, pos - CW'(1)};
  endfunction

  assign tick    = en && (h_cnt == '0) && (v_cnt == '0);
  assign vis     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_act  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_act  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign x       = CW'(h_cnt >> SCALE_SHIFT);
  assign y       = CW'(v_cnt >> SCALE_SHIFT);
  assign bx_step = box_step(bx, dx, BX_MAX);
  assign by_step = box_step(by, dy, BY_MAX);

  // The tick pixel already belongs to the new frame, so it sees the updated state.
  assign mode_eff = tick ? mode_i : mode_q;
  assign bx_eff   = tick ? bx_step[CW-1:0] : bx;
  assign by_eff   = tick ? by_step[CW-1:0] : by;

  assign grad_r = x[4+COLOR_BITS:5];
  assign grad_g = y[4+COLOR_BITS:5];
  assign chk    = x[CHECK_LOG2] ^ y[CHECK_LOG2];
  assign in_box = (x >= bx_eff) && ({1'b0, x} < ({1'b0, bx_eff} + BOX_V)) &&
                  (y >= by_eff) && ({1'b0, y} < ({1'b0, by_eff} + BOX_V));

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= CW'((k * W) / 8)) bar = bar + 3'd1;
    end
  end

  always_comb begin
    pix_r = grad_r;
    pix_g = grad_g;
    pix_b = '0;
    case (mode_eff)
      3'd1: begin
        pix_r = {COLOR_BITS{chk}};
        pix_g = {COLOR_BITS{chk}};
        pix_b = {COLOR_BITS{chk}};
      end
      3'd2: begin
        // bar index bits map directly onto white..black ordering
        pix_r = {COLOR_BITS{~bar[1]}};
        pix_g = {COLOR_BITS{~bar[2]}};
        pix_b = {COLOR_BITS{~bar[0]}};
      end
      3'd3: {pix_r, pix_g, pix_b} = solid_rgb_i;
      3'd4: begin
        if (in_box) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      default: ;
    endcase
    if (!vis) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= '0;
      bx          <= '0;
      by          <= '0;
      dx          <= 1'b1;
      dy          <= 1'b1;
      frame_cnt   <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
      if (tick) begin
        mode_q    <= mode_i;
        frame_cnt <= frame_cnt + 16'd1;
        {dx, bx}  <= bx_step;
        {dy, by}  <= by_step;
      end
      vga_r       <= pix_r;
      vga_g       <= pix_g;
      vga_b       <= pix_b;
      hsync       <= hs_act ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= vs_act ? SYNC_ACT : ~SYNC_ACT;
      de          <= vis;
      frame_start <= tick;
    end
  end

endmodule
`default_nettype wire
